// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiply engine.
package mult_pkg;

  // Sequencer states of the multiply engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Default operand width; the product is twice as wide.
  localparam int MULT_WIDTH = 16;

  typedef logic [2*MULT_WIDTH-1:0] prod_t;

endpackage : mult_pkg

// File: rtl/shift_add_multiplier_core.sv
// Radix-2 shift-and-add multiplier: one partial product per cycle, fixed
// WIDTH+1 cycle latency from the start edge to the single-cycle done pulse.
module shift_add_multiplier_core
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mult_state_t       r_state;
  mult_state_t       w_next_state;
  logic [PW-1:0]     r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_acc;
  logic [CNT_W-1:0]  r_count;
  logic [PW-1:0]     r_product;
  logic [PW-1:0]     w_acc_next;
  logic              w_last_iter;
  logic              w_unused_mcand_hi;

  // The load register zero-extends the multiplicand; its upper half carries no data here.
  assign w_unused_mcand_hi = ^multiplicand[PW-1:WIDTH];

  // Conditional add shared by the accumulator update and the final product capture.
  assign w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : PW'(0));
  assign w_last_iter = (r_count == CNT_W'(WIDTH - 1));

  assign product = r_product;

  // State register and datapath flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, multiplicand[WIDTH-1:0]};
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CNT_W'(1);
          // Capture the sum including this cycle's add, not the stale accumulator.
          if (w_last_iter) begin
            r_product <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = CALC;
      CALC:    if (w_last_iter) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

endmodule : shift_add_multiplier_core

// File: tb/tb_shift_add_multiplier_core.sv
// Scoreboard bench for shift_add_multiplier_core: the driver predicts each
// accepted operation (product and done cycle), a monitor checks every cycle.
module tb_shift_add_multiplier_core;

  localparam int W    = 16;
  localparam int LAT  = W + 1;

  typedef struct {
    logic [2*W-1:0] prod;
    int             cyc;
  } exp_t;

  logic           clk;
  logic           reset;
  logic           start;
  logic [2*W-1:0] multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  exp_t           q[$];
  int             cyc        = 0;
  int             last_done  = -100;
  int             busy_from  = -100;
  logic [2*W-1:0] last_prod  = '0;
  int             checks     = 0;
  int             errors     = 0;

  shift_add_multiplier_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: one sample per cycle, 1 ns after the rising edge.
  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (!reset) begin
      chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= last_done));
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_done at cycle %0d: got none expected cycle %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected 0", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("product", 64'(product), 64'(e.prod));
          last_prod = e.prod;
        end
      end else begin
        chk("product_hold", 64'(product), 64'(last_prod));
      end
    end
  end

  // Called at a falling edge; presents operands with start for one cycle.
  task automatic issue(input logic [2*W-1:0] mc, input logic [W-1:0] mp);
    logic [2*W-1:0] exp_p;
    multiplicand = mc;
    multiplier   = mp;
    start        = 1'b1;
    if (cyc >= last_done + 1) begin
      exp_p     = (2*W)'(mc[W-1:0]) * (2*W)'(mp);
      busy_from = cyc + 1;
      last_done = cyc + LAT;
      q.push_back('{prod: exp_p, cyc: cyc + LAT});
    end
    @(negedge clk);
    start        = 1'b0;
    multiplicand = $urandom();
    multiplier   = W'($urandom());
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (cyc < last_done + 1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout at cycle %0d: got busy expected idle", cyc);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    q.delete();
    last_done = -100;
    busy_from = -100;
    last_prod = '0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    @(negedge clk);
    do_reset();

    // Directed cases.
    issue(32'h0000_0003, 16'h0005);
    wait_idle();
    issue(32'h0000_FFFF, 16'hFFFF);
    wait_idle();
    issue(32'hABCD_1234, 16'h0000);
    wait_idle();
    issue(32'hFFFF_0002, 16'h0003);
    wait_idle();

    // Start while busy is ignored.
    issue(32'd7, 16'd9);
    repeat (3) @(negedge clk);
    issue(32'd2, 16'd2);
    wait_idle();
    @(negedge clk);

    // Reset in the middle of an operation, then a fresh multiply.
    issue(32'd100, 16'd100);
    repeat (6) @(negedge clk);
    do_reset();
    issue(32'd4, 16'd4);
    wait_idle();

    // Back-to-back: second start in the first IDLE cycle after done.
    issue(32'd12, 16'd12);
    wait_idle();
    issue(32'h0000_1234, 16'h0010);
    wait_idle();

    // Random operands, gaps and stray starts while busy.
    for (int i = 0; i < 40; i++) begin
      issue($urandom(), W'($urandom()));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 12)) @(negedge clk);
        issue($urandom(), W'($urandom()));
      end
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_add_multiplier_core

// File: doc/shift_add_multiplier_core.md
Name: shift_add_multiplier_core

Overview:
- Radix-2 shift-and-add multiply engine, directly downstream of the multiplicand load register.
- Consumes the zero-extended 32-bit multiplicand word and a 16-bit multiplier.
- Produces a 32-bit unsigned product after a fixed number of iterations.
- Uses a start/busy/done handshake toward the sequencing controller.

Parameters:
- WIDTH, 16, operand width in bits. Product and internal multiplicand width is 2*WIDTH, held as a derived localparam PW.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request new multiply; sampled only in IDLE
- multiplicand  input  2*WIDTH  zero-extended multiplicand word from the load register; only bits [WIDTH-1:0] are used, upper bits ignored
- multiplier  input  WIDTH  unsigned multiplier operand
- busy  output  1  high while an operation is in progress (CALC or DONE)
- done  output  1  single-cycle pulse; product is valid in that cycle
- product  output  2*WIDTH  unsigned product; holds last result until next completion

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-high on reset, with all flops in one always_ff on posedge clk or posedge reset.
- Reset values:
  - state=IDLE
  - busy=0, done=0, product=0
  - mcand_r=0, mplier_r=0, acc=0, count=0
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - busy=0.
  - If start=1 at a clock edge:
    - mcand_r <= {WIDTH'b0, multiplicand[WIDTH-1:0]}
    - mplier_r <= multiplier
    - acc <= 0
    - count <= 0
    - go to CALC
- CALC, one iteration per cycle:
  - If mplier_r[0], then acc <= acc + mcand_r, truncated to PW bits. No overflow is possible for unsigned WIDTH x WIDTH.
  - mcand_r <= mcand_r << 1
  - mplier_r <= mplier_r >> 1 (zero fill)
  - count <= count + 1
  - When count == WIDTH-1, the final add completes this cycle. The next state is DONE, and product <= final accumulated value, computed from acc plus the conditional add, not the stale acc.
- DONE:
  - done=1 for exactly this one cycle, busy=1.
  - Return to IDLE unconditionally.
- Latency:
  - Start sampled at edge E0.
  - CALC occupies the cycles after edges E0..E(WIDTH-1).
  - DONE (done=1, product valid) occupies the cycle after edge E(WIDTH).
  - Total is WIDTH+1 cycles from start to done. Fixed: no early termination on a zero multiplier.
- busy = (state != IDLE), registered or decoded from the state register; no combinational path from start.
- done = (state == DONE), decoded from the state register.
- start while busy (CALC or DONE) is ignored. No queuing; the operands of the running operation are unaffected.
- start in the IDLE cycle immediately after DONE is accepted, so back-to-back operations take WIDTH+2 cycles each.
- Operand inputs may change freely after the start edge; only the values latched at the start edge matter.
- Reset mid-operation: returns immediately to the reset values. product is cleared to 0 and no done pulse is produced.
- product changes only on the edge entering DONE, or on reset.

Decomposition:
- Package mult_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t
  - localparam int MULT_WIDTH = 16
  - typedef logic [2*MULT_WIDTH-1:0] prod_t
- No sub-module. The datapath (add/shift) and the FSM are small enough to live together. The conditional adder is coded inline as a combinational next-acc term shared by the acc update and the product capture.

Test Plan:
- Basic multiply: reset, then start with multiplicand=32'h0000_0003, multiplier=16'h0005 → busy rises on the next cycle, done=1 exactly 17 cycles after the start edge, product=32'h0000_000F, done low the following cycle.
- Max operands: multiplicand=32'h0000_FFFF, multiplier=16'hFFFF → product=32'hFFFE_0001.
- Zero operands and ignored upper bits:
  - multiplicand=32'hABCD_1234 with multiplier=16'h0000 → product=0 with the full 17-cycle latency.
  - multiplicand=32'hFFFF_0002 with multiplier=16'h0003 → product=32'h0000_0006 (upper bits ignored).
- Start while busy: start 7×9, pulse start with 2×2 at cycle 5 → single done, product=32'h0000_003F, no second done.
- Reset mid-operation: start 100×100, assert reset at cycle 8 → busy=0, done=0, product=0 immediately; after release, start 4×4 → product=32'h0000_0010 at the expected cycle.
- Back-to-back: start re-asserted in the first IDLE cycle after done (12×12 then 0x1234×0x10) → products 32'h0000_0090 then 32'h0001_2340, done pulses 18 cycles apart.
